// File: rtl/keypad_emulator_pkg.sv
// keypad_pkg: shared types and constants for the keypad emulator.
//   kemu_state_t  - press/release sequencing states
//   key_code_t    - key code layout: column index in [3:2], row index in [1:0]
//   TICK_CNT_W    - width of the tick counter (limits up to 1023)
//   row_onehot()  - row index to one-hot row-line pattern
package keypad_pkg;

    localparam int TICK_CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        RELEASE_BOUNCE,
        GAP
    } kemu_state_t;

    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } key_code_t;

    function automatic logic [3:0] row_onehot(input logic [1:0] row);
        return 4'b0001 << row;
    endfunction

endpackage

// File: rtl/kemu_tick_counter.sv
// kemu_tick_counter: counts tick_i pulses while enabled and flags the tick
// that brings the count up to limit_i.
//   clk, rst_i  - clock and asynchronous active-low reset
//   clear_i     - synchronous clear, wins over counting (state entry)
//   en_i        - counting enable
//   tick_i      - timebase enable pulse
//   limit_i     - number of ticks to count (1..1023)
//   done_o      - combinational: this tick is the limit_i-th one
module kemu_tick_counter
    import keypad_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic                  tick_i,
    input  logic [TICK_CNT_W-1:0] limit_i,
    output logic                  done_o
);

    logic [TICK_CNT_W-1:0] cnt_q;
    logic [TICK_CNT_W-1:0] cnt_d;

    // done_o must not depend on clear_i: the owner derives clear_i from the
    // next state, which itself depends on done_o.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && tick_i) begin
            cnt_d = cnt_q + 1'b1;
        end
        done_o = en_i && tick_i && (cnt_q == (limit_i - 1'b1));
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: behavioural 4x4 matrix keypad built as synthesizable RTL.
// A key code accepted over req/busy is "held" for HOLD_TICKS ticks; while
// held, the row line of the key is raised whenever the scanner drives the
// key's column. A released GAP of GAP_TICKS ticks follows, ended by done_o.
// Optional macro KEYPAD_EMU_BOUNCE_EN adds BOUNCE_TICKS-long bounce phases
// on press and release; without it both edges are clean.
//   clk         - system clock
//   rst_i       - asynchronous active-low reset
//   tick_i      - single-cycle timebase enable
//   req_i       - press request, sampled only in IDLE
//   key_i       - key code {col[1:0], row[1:0]}
//   col_i       - column currently driven by the scanner
//   fila_o      - registered row lines, one-hot or zero
//   row_code_o  - registered row index while fila_o != 0, else 0
//   busy_o      - key sequence in progress
//   done_o      - one-cycle pulse in the first IDLE cycle after GAP
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_TICKS   = 50,
    parameter int GAP_TICKS    = 20,
    parameter int BOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       req_i,
    input  logic [3:0] key_i,
    input  logic [1:0] col_i,
    output logic [3:0] fila_o,
    output logic [1:0] row_code_o,
    output logic       busy_o,
    output logic       done_o
);

    kemu_state_t           state_q, state_d;
    key_code_t             key_q, key_d;
    logic [3:0]            fila_q, fila_d;
    logic [1:0]            row_q, row_d;
    logic                  done_q, done_d;
    logic                  cnt_done;
    logic                  cnt_en;
    logic                  cnt_clear;
    logic [TICK_CNT_W-1:0] cnt_limit;
    logic                  pressed;
    logic                  col_match;

    // Limit for whichever state is counting.
    always_comb begin
        cnt_limit = TICK_CNT_W'(1);
        case (state_q)
            PRESS_BOUNCE,
            RELEASE_BOUNCE: cnt_limit = TICK_CNT_W'(BOUNCE_TICKS);
            HOLD:           cnt_limit = TICK_CNT_W'(HOLD_TICKS);
            GAP:            cnt_limit = TICK_CNT_W'(GAP_TICKS);
            default:        cnt_limit = TICK_CNT_W'(1);
        endcase
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    assign cnt_en = (state_q != IDLE);
`else
    assign cnt_en = (state_q == HOLD) || (state_q == GAP);
`endif

    // Clearing on every state change means a tick sampled on an entry edge
    // is never counted by the new state.
    assign cnt_clear = (state_d != state_q);

    kemu_tick_counter u_tick_counter (
        .clk     (clk),
        .rst_i   (rst_i),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .tick_i  (tick_i),
        .limit_i (cnt_limit),
        .done_o  (cnt_done)
    );

    // Next-state logic; done is registered so it lands in the first IDLE
    // cycle, the same cycle busy_o drops.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = PRESS_BOUNCE;
                    key_d   = key_code_t'(key_i);
                end
            end
            PRESS_BOUNCE: begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                if (cnt_done) state_d = HOLD;
`else
                state_d = HOLD;
`endif
            end
            HOLD: begin
                if (cnt_done) state_d = RELEASE_BOUNCE;
            end
            RELEASE_BOUNCE: begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                if (cnt_done) state_d = GAP;
`else
                state_d = GAP;
`endif
            end
            GAP: begin
                if (cnt_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic lvl_q, lvl_d;

    // Bounce level: starts closed on press, open on release, flips per tick.
    always_comb begin
        lvl_d = lvl_q;
        if (state_q == IDLE && state_d == PRESS_BOUNCE) begin
            lvl_d = 1'b1;
        end else if (state_q == HOLD && state_d == RELEASE_BOUNCE) begin
            lvl_d = 1'b0;
        end else if ((state_q == PRESS_BOUNCE || state_q == RELEASE_BOUNCE) && tick_i) begin
            lvl_d = ~lvl_q;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    assign pressed = (state_q == HOLD) ||
                     ((state_q == PRESS_BOUNCE || state_q == RELEASE_BOUNCE) && lvl_q);
`else
    assign pressed = (state_q == HOLD);
`endif

    assign col_match = (col_i == key_q.col);

    always_comb begin
        fila_d = '0;
        row_d  = '0;
        if (pressed && col_match) begin
            fila_d = row_onehot(key_q.row);
            row_d  = key_q.row;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            key_q   <= '0;
            fila_q  <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            fila_q  <= fila_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    assign fila_o     = fila_q;
    assign row_code_o = row_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: drives two emulator instances (HOLD/GAP = 3/2 and 1/1)
// with the same stimulus and compares each against a segment-table model of
// a key press: press-bounce, hold, release-bounce, gap, each lasting a given
// number of ticks (0 meaning "one clock, no tick needed").
module tb_keypad_emulator;

    localparam int BT = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic       clk;
    logic       rst_i;
    logic       tick_i;
    logic       req_i;
    logic [3:0] key_i;
    logic [1:0] col_i;
    logic [3:0] dutFila [2];
    logic [1:0] dutRow  [2];
    logic       dutBusy [2];
    logic       dutDone [2];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state per unit.
    bit         mBusy  [2];
    logic [3:0] mKey   [2];
    int         mSeg   [2];
    int         mTicks [2];
    logic [3:0] eFila  [2];
    logic [1:0] eRow   [2];
    logic       eDone  [2];

    keypad_emulator #(.HOLD_TICKS(3), .GAP_TICKS(2), .BOUNCE_TICKS(BT)) u_dut0 (
        .clk(clk), .rst_i(rst_i), .tick_i(tick_i), .req_i(req_i), .key_i(key_i),
        .col_i(col_i), .fila_o(dutFila[0]), .row_code_o(dutRow[0]),
        .busy_o(dutBusy[0]), .done_o(dutDone[0])
    );

    keypad_emulator #(.HOLD_TICKS(1), .GAP_TICKS(1), .BOUNCE_TICKS(BT)) u_dut1 (
        .clk(clk), .rst_i(rst_i), .tick_i(tick_i), .req_i(req_i), .key_i(key_i),
        .col_i(col_i), .fila_o(dutFila[1]), .row_code_o(dutRow[1]),
        .busy_o(dutBusy[1]), .done_o(dutDone[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick length of each segment of a key press for a given unit.
    function automatic int segLen(int u, int s);
        case (s)
            0, 2:    return BOUNCE ? BT : 0;
            1:       return (u == 0) ? 3 : 1;
            default: return (u == 0) ? 2 : 1;
        endcase
    endfunction

    // Whether the key contacts are closed at this point of the press.
    function automatic bit segPressed(int s, int t);
        case (s)
            0:       return BOUNCE && (t % 2 == 0);
            1:       return 1'b1;
            2:       return BOUNCE && (t % 2 == 1);
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        for (int u = 0; u < 2; u++) begin
            mBusy[u] = 0; mKey[u] = '0; mSeg[u] = 0; mTicks[u] = 0;
            eFila[u] = '0; eRow[u] = '0; eDone[u] = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep(int u);
        bit p;
        int d;
        p = mBusy[u] && segPressed(mSeg[u], mTicks[u]);
        if (p && col_i == mKey[u][3:2]) begin
            eFila[u] = 4'b0001 << mKey[u][1:0];
            eRow[u]  = mKey[u][1:0];
        end else begin
            eFila[u] = '0;
            eRow[u]  = '0;
        end
        eDone[u] = 1'b0;
        if (!mBusy[u]) begin
            if (req_i) begin
                mBusy[u] = 1; mKey[u] = key_i; mSeg[u] = 0; mTicks[u] = 0;
            end
        end else begin
            d = segLen(u, mSeg[u]);
            if (d == 0) begin
                mSeg[u]++; mTicks[u] = 0;
            end else if (tick_i) begin
                if (mTicks[u] + 1 == d) begin
                    if (mSeg[u] == 3) begin
                        mBusy[u] = 0; eDone[u] = 1'b1;
                    end else begin
                        mSeg[u]++;
                    end
                    mTicks[u] = 0;
                end else begin
                    mTicks[u]++;
                end
            end
        end
    endtask

    task automatic checkOne(string tag, logic [3:0] obs, logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int u = 0; u < 2; u++) begin
            checkOne($sformatf("u%0d fila_o", u), dutFila[u], eFila[u]);
            checkOne($sformatf("u%0d row_code_o", u), {2'b00, dutRow[u]}, {2'b00, eRow[u]});
            checkOne($sformatf("u%0d busy_o", u), {3'b000, dutBusy[u]}, {3'b000, mBusy[u]});
            checkOne($sformatf("u%0d done_o", u), {3'b000, dutDone[u]}, {3'b000, eDone[u]});
        end
    endtask

    // Apply one clock of inputs, step the model, then compare after the edge.
    task automatic applyStimulus(logic r, logic [3:0] k, logic [1:0] c, logic t);
        req_i = r; key_i = k; col_i = c; tick_i = t;
        modelStep(0);
        modelStep(1);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [1:0] c;
        bit found;

        rst_i = 1'b0; tick_i = 1'b0; req_i = 1'b0; key_i = '0; col_i = '0;
        modelReset();
        #12;
        checkOutput();
        rst_i = 1'b1;

        // Basic press with matched column.
        applyStimulus(1'b1, 4'b1001, 2'b10, 1'b0);
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 4'b1001, 2'b10, (i % 4) == 3);

        // Scanner sweeping columns, one step per tick.
        c = 2'b00;
        applyStimulus(1'b1, 4'b1001, c, 1'b0);
        for (int i = 0; i < 90; i++) begin
            if (i % 3 == 2) c = c + 2'b01;
            applyStimulus(1'b0, 4'b1001, c, (i % 3) == 2);
        end

        // Request while busy is ignored; held request re-triggers after done.
        applyStimulus(1'b1, 4'b1001, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1001, 2'b10, 1'b0);
        for (int i = 0; i < 80; i++) applyStimulus(1'b1, 4'b0000, 2'(i), (i % 2) == 1);
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 4'b0000, 2'(i), (i % 2) == 1);

        // Tick coincident with acceptance is not counted.
        applyStimulus(1'b1, 4'b0111, 2'b01, 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 4'b0111, 2'b01, (i % 3) == 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(0, 9) == 0, 4'($urandom), 2'($urandom),
                          $urandom_range(0, 3) == 0);

        // Drain, then reset in the middle of HOLD.
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 4'b1001, 2'b10, 1'b1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mBusy[0] && mSeg[0] == 1) found = 1;
            else applyStimulus(i == 0, 4'b1001, 2'b10, (i % 3) == 2);
        end
        applyStimulus(1'b0, 4'b1001, 2'b10, 1'b0);
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("[TB] FAIL reach_hold observed=%0d expected=1", found);
        end
        #2;
        rst_i = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 4'b1001, 2'b10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Behavioural stand-in for the 4x4 matrix keypad, built as synthesizable RTL.
- Receives a key code over a req/busy handshake.
- Watches the scanner's 2-bit column drive and asserts the matching row line, plus the encoded row code, while the key is "held".
- Sits opposite the keypad scanner, either on-board (loopback self-test replacing the physical keypad) or in scanner benches, so scanner, counter-stop and key encoding can be exercised without hardware.

Parameters:
HOLD_TICKS, 50, key-held duration in tick_i pulses (legal 1..1023)
GAP_TICKS, 20, mandatory released time after each key before done, in tick_i pulses (legal 1..1023)
BOUNCE_TICKS, 4, bounce window length per edge in tick_i pulses (used only with bounce feature, legal 1..63)

Ports:
clk  input  1  system clock (10 MHz)
rst_i  input  1  asynchronous active-low reset
tick_i  input  1  single-cycle timebase enable from clock divider (nominal 1 kHz)
req_i  input  1  request to press key_i; sampled only in IDLE
key_i  input  4  key code: [3:2] column index 0..3, [1:0] row index 0..3
col_i  input  2  column currently driven by scanner counter (binary)
fila_o  output  4  row lines, active-high, one-hot or zero
row_code_o  output  2  encoded row index (E1=bit1, E2=bit0), valid while any fila_o bit is high, else 0
busy_o  output  1  high from the cycle after acceptance until done_o
done_o  output  1  one-cycle pulse at end of GAP

Behaviour:
- Reset (rst_i=0, async): state IDLE, all counters 0, latched key 0, fila_o=0, row_code_o=0, busy_o=0, done_o=0.
- FSM states:
  - IDLE -> PRESS_BOUNCE on req_i=1.
  - PRESS_BOUNCE -> HOLD after BOUNCE_TICKS ticks.
  - HOLD -> RELEASE_BOUNCE after HOLD_TICKS ticks.
  - RELEASE_BOUNCE -> GAP after BOUNCE_TICKS ticks.
  - GAP -> IDLE after GAP_TICKS ticks, with done_o=1 in the transition cycle.
- Without the bounce feature, both bounce states last 0 cycles: PRESS_BOUNCE->HOLD and RELEASE_BOUNCE->GAP on the next clk with no tick needed.
- Acceptance: key_i is latched on the clk edge where state=IDLE and req_i=1; busy_o=1 from the next cycle. req_i while busy_o=1 is ignored (no queue, no error). req_i held high through done re-triggers on the cycle after done_o (IDLE lasts 1 cycle).
- Tick counting:
  - The counter clears on every state entry and increments only on tick_i=1.
  - A state exits on the clk edge where the count reaches its limit with tick_i=1.
  - HOLD therefore lasts exactly HOLD_TICKS tick pulses.
  - A tick coinciding with state entry is not counted.
- Row drive:
  - pressed = (state==HOLD) or bounce-phase pressed level.
  - fila_o registered: fila_o[row] <= pressed && (col_i == latched column); all other bits 0.
  - Latency col_i -> fila_o is 1 clk.
  - row_code_o registered in the same cycle, equal to the latched row when fila_o != 0, else 0.
- Column mismatch: fila_o=0 even in HOLD; scanner continues counting.
- done_o and busy_o: done_o is never high with busy_o low in the same cycle except the done cycle itself (busy_o drops with done_o).
- Reset mid-operation: immediate return to IDLE, outputs zero; no done_o pulse.

Optional Feature:
- Macro KEYPAD_EMU_BOUNCE_EN.
- Defined:
  - In PRESS_BOUNCE and RELEASE_BOUNCE, the pressed level toggles on every tick_i, starting pressed=1 in PRESS_BOUNCE and pressed=0 in RELEASE_BOUNCE.
  - Each bounce state lasts BOUNCE_TICKS ticks.
  - Exercises the scanner debouncer.
- Undefined: clean edges and zero-length bounce states; BOUNCE_TICKS is unused.

Decomposition:
- Package keypad_pkg:
  - typedef enum logic [2:0] kemu_state_t {IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP}.
  - typedef struct packed key_code_t {logic [1:0] col; logic [1:0] row}.
  - localparam TICK_CNT_W = 10.
- One natural sub-module, kemu_tick_counter: clear/enable/limit-compare counter raising a done flag, instantiated once and reused across states.

Test Plan:
1. Reset: rst_i=0 mid-HOLD with key 4'b1001 -> fila_o=0, row_code_o=0, busy_o=0 within the same cycle; no done_o afterwards.
2. Basic press, bounce macro off, HOLD_TICKS=3, GAP_TICKS=2: req_i with key_i=4'b1001, col_i=2'b10 -> fila_o=4'b0010 and row_code_o=2'b01 for exactly 3 ticks; done_o after 2 further ticks.
3. Scanning: same key, col_i cycling 0..3 each tick -> fila_o=4'b0010 only during col_i=2 cycles (+1 clk latency), 0 otherwise.
4. Handshake: second req_i with key_i=4'b0000 while busy_o=1 -> ignored, latched key unchanged; req_i held high -> new acceptance on the cycle after done_o.
5. Bounce, KEYPAD_EMU_BOUNCE_EN defined, BOUNCE_TICKS=4, col matched:
   - fila_o pattern per tick is 1,0,1,0, then solid for HOLD.
   - Release bounce is 0,1,0,1, then 0 for GAP.
6. Tick coincident with req_i acceptance: that tick is not counted; with HOLD_TICKS=1, HOLD ends on the first tick after entry.
